// File: rtl/fifowrarb_if.sv
// fifowrarb_if: requester-side valid/ready streams
// sharing the FIFO write port.
interface fifowrarb_if #(
  parameter int nreq  = 4,
  parameter int width = 8
);
  logic [nreq-1:0]       reqvalid;
  logic [nreq*width-1:0] reqdata;
  logic [nreq-1:0]       reqready;

  modport master (
    output reqvalid,
    output reqdata,
    input  reqready
  );

  modport slave (
    input  reqvalid,
    input  reqdata,
    output reqready
  );
endinterface

// File: rtl/fifowrarb.sv
// fifowrarb: round-robin arbiter granting one requester
// at a time a bounded burst into the FIFO write port.
module fifowrarb #(
  parameter int nreq     = 4,
  parameter int width    = 8,
  parameter int maxburst = 4
) (
  input  logic             clk,
  input  logic             resetn,
  fifowrarb_if.slave       rq,
  input  logic             full,
  output logic             we,
  output logic [width-1:0] datain,
  output logic [nreq-1:0]  grant,
  output logic             busy,
  output logic [15:0]      wrcount
);
  localparam int pw = (nreq > 1) ? $clog2(nreq) : 1;
  localparam int bw = $clog2(maxburst + 1);
  localparam logic [nreq-1:0] onebit = nreq'(1);

  typedef enum logic {
    idle,
    burst
  } state_t;

  state_t           st;
  logic [pw-1:0]    rrptr;
  logic [pw-1:0]    owner;
  logic [pw-1:0]    pick;
  logic [pw-1:0]    idx;
  logic [pw-1:0]    nxt;
  logic [bw-1:0]    beats;
  logic             found;
  logic             ovalid;
  logic             accept;
  logic             last;
  logic             done;
  logic [width-1:0] odata;

  // first valid requester at or after rrptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < nreq; i++) begin
      idx = pw'((int'(rrptr) + i) % nreq);
      if (!found && rq.reqvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign ovalid = rq.reqvalid[owner];
  assign odata  = rq.reqdata[int'(owner) * width +: width];
  assign nxt    = pw'((int'(owner) + 1) % nreq);
  assign accept = (st == burst) && ovalid && !full;
  assign last   = accept &&
                  (int'(beats) + 1 == maxburst);
  assign done   = last || !ovalid || full;

  // only the owner sees ready, gated by the near-full flag
  always_comb begin
    rq.reqready = '0;
    if (st == burst)
      rq.reqready[owner] = ovalid && !full;
  end

  // arbitration, burst bookkeeping and registered write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st      <= idle;
      rrptr   <= '0;
      owner   <= '0;
      beats   <= '0;
      we      <= 1'b0;
      datain  <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      wrcount <= '0;
    end else begin
      we <= accept;
      if (accept) begin
        datain  <= odata;
        wrcount <= wrcount + 16'd1;
        beats   <= beats + 1'b1;
      end
      unique case (st)
        idle: begin
          if (found) begin
            owner <= pick;
            grant <= onebit << pick;
            beats <= '0;
            busy  <= 1'b1;
            st    <= burst;
          end
        end
        burst: begin
          if (done) begin
            grant <= '0;
            busy  <= 1'b0;
            rrptr <= nxt;
            st    <= idle;
          end
        end
        default: st <= idle;
      endcase
    end
  end
endmodule

// File: tb/tb_fifowrarb.sv
// tb_fifowrarb: directed and randomized checks of the
// round-robin FIFO write arbiter against a reference model.
module tb_fifowrarb;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int WRAPN = 65540;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fifowrarb_if #(.nreq(NR), .width(W)) rq();
  logic          full;
  logic          we;
  logic [W-1:0]  datain;
  logic [NR-1:0] grant;
  logic          busy;
  logic [15:0]   wrcount;

  fifowrarb #(.nreq(NR), .width(W), .maxburst(MB)) dut (
    .clk(clk), .resetn(resetn), .rq(rq),
    .full(full), .we(we), .datain(datain),
    .grant(grant), .busy(busy), .wrcount(wrcount)
  );

  fifowrarb_if #(.nreq(2), .width(W)) wq();
  logic         wfull;
  logic         wwe;
  logic [W-1:0] wdin;
  logic [1:0]   wgrant;
  logic         wbusy;
  logic [15:0]  wcnt;

  fifowrarb #(.nreq(2), .width(W), .maxburst(255)) dutw (
    .clk(clk), .resetn(resetn), .rq(wq),
    .full(wfull), .we(wwe), .datain(wdin),
    .grant(wgrant), .busy(wbusy), .wrcount(wcnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model state, spec-level
  int m_busy, m_owner, m_rr, m_beats;
  int m_we, m_din, m_wr;

  function automatic void m_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    m_we = 0; m_din = 0; m_wr = 0;
  endfunction

  function automatic logic [NR-1:0] m_ready(
    logic [NR-1:0] v, logic f);
    logic [NR-1:0] r;
    r = '0;
    if (m_busy != 0 && v[m_owner] && !f) r[m_owner] = 1'b1;
    return r;
  endfunction

  function automatic void m_clock(
    logic [NR-1:0] v, logic [NR*W-1:0] d, logic f);
    int j;
    bit got;
    bit acc;
    if (m_busy == 0) begin
      m_we = 0;
      got = 0;
      for (int k = 0; k < NR; k++) begin
        j = (m_rr + k) % NR;
        if (!got && v[j]) begin
          got = 1;
          m_owner = j;
        end
      end
      if (got) begin
        m_busy = 1;
        m_beats = 0;
      end
    end else begin
      acc = v[m_owner] && !f;
      if (acc) begin
        m_we = 1;
        m_din = int'(d[m_owner*W +: W]);
        m_beats = m_beats + 1;
        m_wr = (m_wr + 1) % 65536;
      end else begin
        m_we = 0;
      end
      if ((acc && m_beats == MB) || !v[m_owner] || f) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % NR;
      end
    end
  endfunction

  logic [NR-1:0] o_ready, e_ready, o_grant, e_grant;
  logic          o_we, e_we, o_busy, e_busy;
  logic [W-1:0]  o_din, e_din;
  logic [15:0]   o_wr, e_wr;

  // one clock cycle: drive, observe mid-cycle, advance model
  task automatic cyc(input logic [NR-1:0] v,
                     input logic [NR*W-1:0] d,
                     input logic f);
    @(negedge clk);
    rq.reqvalid = v;
    rq.reqdata = d;
    full = f;
    #1;
    o_ready = rq.reqready;
    o_we = we;
    o_din = datain;
    o_grant = grant;
    o_busy = busy;
    o_wr = wrcount;
    e_ready = m_ready(v, f);
    e_we = (m_we != 0);
    e_din = W'(m_din);
    e_grant = (m_busy != 0) ? NR'(1 << m_owner) : '0;
    e_busy = (m_busy != 0);
    e_wr = 16'(m_wr);
    @(posedge clk);
    m_clock(v, d, f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    rq.reqvalid = '0;
    full = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    rq.reqvalid = '1;
    rq.reqdata = $urandom;
    full = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL reset_we got %0h want 0", we);
    end
    checks++;
    if (datain !== '0) begin
      errors++;
      $display("FAIL reset_datain got %0h want 0", datain);
    end
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL reset_grant got %0h want 0", grant);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %0h want 0", busy);
    end
    checks++;
    if (wrcount !== 16'd0) begin
      errors++;
      $display("FAIL reset_wrcount got %0h want 0", wrcount);
    end
    checks++;
    if (rq.reqready !== '0) begin
      errors++;
      $display("FAIL reset_ready got %0h want 0", rq.reqready);
    end
    @(negedge clk);
    rq.reqvalid = '0;
    resetn = 1'b1;
    m_reset();
  endtask

  task automatic test_single();
    logic [7:0] q[$];
    logic [7:0] wd[$];
    int wc[$];
    logic [NR-1:0] v;
    logic [NR*W-1:0] d;
    do_reset();
    for (int k = 0; k < 6; k++) q.push_back(8'(8'h10 + k));
    for (int t = 0; t < 16; t++) begin
      v = (q.size() > 0) ? NR'(1) : '0;
      d = (q.size() > 0) ? (NR*W)'(q[0]) : '0;
      cyc(v, d, 1'b0);
      if (o_ready[0] && v[0]) void'(q.pop_front());
      if (o_we) begin
        wd.push_back(o_din);
        wc.push_back(t);
      end
    end
    checks++;
    if (wd.size() != 6) begin
      errors++;
      $display("FAIL single_nwrites got %0d want 6", wd.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wd[k] !== 8'(8'h10 + k)) begin
          errors++;
          $display("FAIL single_data%0d got %0h want %0h",
                   k, wd[k], 8'h10 + k);
        end
      end
      checks++;
      if (wc[3] - wc[0] != 3) begin
        errors++;
        $display("FAIL single_run got %0d want 3", wc[3] - wc[0]);
      end
      checks++;
      if (wc[4] - wc[3] != 2) begin
        errors++;
        $display("FAIL single_gap got %0d want 2", wc[4] - wc[3]);
      end
    end
    checks++;
    if (o_wr !== 16'd6) begin
      errors++;
      $display("FAIL single_wrcount got %0d want 6", o_wr);
    end
  endtask

  task automatic test_all_valid();
    logic [NR-1:0] gseq[$];
    int gaps[$];
    int cnt[8];
    logic [NR-1:0] prev;
    logic [NR-1:0] want;
    int gap;
    do_reset();
    prev = '0;
    gap = 0;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int t = 0; t < 24; t++) begin
      cyc('1, {$urandom}, 1'b0);
      if (o_grant == '0) gap++;
      else if (prev == '0) begin
        gseq.push_back(o_grant);
        gaps.push_back(gap);
        gap = 0;
      end
      if (o_ready != '0 && gseq.size() > 0 && gseq.size() <= 8)
        cnt[gseq.size()-1]++;
      prev = o_grant;
    end
    checks++;
    if (gseq.size() != 5) begin
      errors++;
      $display("FAIL allv_ngrants got %0d want 5", gseq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        want = NR'(1) << (k % NR);
        checks++;
        if (gseq[k] !== want) begin
          errors++;
          $display("FAIL allv_order%0d got %0h want %0h",
                   k, gseq[k], want);
        end
        checks++;
        if (gaps[k] != 1) begin
          errors++;
          $display("FAIL allv_gap%0d got %0d want 1", k, gaps[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cnt[k] != MB) begin
          errors++;
          $display("FAIL allv_beats%0d got %0d want %0d",
                   k, cnt[k], MB);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [NR*W-1:0] d;
    do_reset();
    d = $urandom;
    cyc(4'b0010, d, 1'b0);
    cyc(4'b0110, d, 1'b0);
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL full_grant1 got %0h want 2", o_grant);
    end
    cyc(4'b0110, d, 1'b0);
    cyc(4'b0110, d, 1'b1);
    checks++;
    if (o_ready !== 4'b0000) begin
      errors++;
      $display("FAIL full_ready got %0h want 0", o_ready);
    end
    checks++;
    if (o_we !== 1'b1) begin
      errors++;
      $display("FAIL full_we2 got %0h want 1", o_we);
    end
    cyc(4'b0110, d, 1'b0);
    checks++;
    if (o_we !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_idle got we=%0h busy=%0h want 0 0",
               o_we, o_busy);
    end
    cyc(4'b0110, d, 1'b0);
    checks++;
    if (o_grant !== 4'b0100) begin
      errors++;
      $display("FAIL full_next got %0h want 4", o_grant);
    end
    checks++;
    if (o_wr !== 16'd2) begin
      errors++;
      $display("FAIL full_wrcount got %0d want 2", o_wr);
    end
  endtask

  task automatic test_drop();
    logic [NR-1:0] v3;
    logic [NR-1:0] want;
    for (int k = 0; k < 2; k++) begin
      v3 = (k == 0) ? 4'b1001 : 4'b0001;
      want = (k == 0) ? 4'b1000 : 4'b0001;
      do_reset();
      cyc(4'b0100, {$urandom}, 1'b0);
      cyc(4'b0101, {$urandom}, 1'b0);
      cyc(4'b0001, {$urandom}, 1'b0);
      checks++;
      if (o_ready !== 4'b0000) begin
        errors++;
        $display("FAIL drop_ready%0d got %0h want 0", k, o_ready);
      end
      cyc(v3, {$urandom}, 1'b0);
      cyc(v3, {$urandom}, 1'b0);
      checks++;
      if (o_grant !== want) begin
        errors++;
        $display("FAIL drop_next%0d got %0h want %0h",
                 k, o_grant, want);
      end
      checks++;
      if (o_wr !== 16'd1) begin
        errors++;
        $display("FAIL drop_wrcount%0d got %0d want 1", k, o_wr);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(4'b0001, {$urandom}, 1'b0);
    cyc(4'b0001, {$urandom}, 1'b0);
    cyc(4'b0001, {$urandom}, 1'b0);
    @(negedge clk);
    rq.reqvalid = 4'b0001;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_out got we=%0h grant=%0h busy=%0h want 0",
               we, grant, busy);
    end
    checks++;
    if (rq.reqready !== '0 || wrcount !== 16'd0) begin
      errors++;
      $display("FAIL mid_ready_cnt got %0h %0h want 0 0",
               rq.reqready, wrcount);
    end
    @(negedge clk);
    rq.reqvalid = '0;
    resetn = 1'b1;
    m_reset();
    cyc('1, {$urandom}, 1'b0);
    checks++;
    if (o_we !== 1'b0 || o_grant !== '0) begin
      errors++;
      $display("FAIL mid_release got we=%0h grant=%0h want 0 0",
               o_we, o_grant);
    end
    cyc('1, {$urandom}, 1'b0);
    checks++;
    if (o_grant !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first got %0h want 1", o_grant);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] v;
    logic f;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      for (int k = 0; k < NR; k++) v[k] = ($urandom % 4) != 0;
      f = ($urandom % 6) == 0;
      cyc(v, {$urandom}, f);
      checks++;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL rnd_ready t=%0d got %0h want %0h",
                 t, o_ready, e_ready);
      end
      checks++;
      if (o_we !== e_we || o_din !== e_din) begin
        errors++;
        $display("FAIL rnd_write t=%0d got %0h/%0h want %0h/%0h",
                 t, o_we, o_din, e_we, e_din);
      end
      checks++;
      if (o_grant !== e_grant || o_busy !== e_busy) begin
        errors++;
        $display("FAIL rnd_grant t=%0d got %0h/%0h want %0h/%0h",
                 t, o_grant, o_busy, e_grant, e_busy);
      end
      checks++;
      if (o_wr !== e_wr) begin
        errors++;
        $display("FAIL rnd_wrcount t=%0d got %0d want %0d",
                 t, o_wr, e_wr);
      end
    end
  endtask

  task automatic test_wrap();
    int acc;
    int wes;
    int tail;
    bit done;
    acc = 0;
    wes = 0;
    tail = 0;
    done = 0;
    for (int t = 0; t < 70000 && !done; t++) begin
      @(negedge clk);
      wq.reqvalid = (acc < WRAPN) ? 2'b01 : 2'b00;
      wq.reqdata = {8'h00, W'(acc)};
      #1;
      if (wq.reqready[0] && wq.reqvalid[0]) acc++;
      if (wwe) wes++;
      if (acc >= WRAPN) tail++;
      if (tail > 5) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wrap_timeout got %0d beats want %0d", acc, WRAPN);
    end
    checks++;
    if (wcnt !== 16'd4) begin
      errors++;
      $display("FAIL wrap_wrcount got %0d want 4", wcnt);
    end
    checks++;
    if (wes != WRAPN) begin
      errors++;
      $display("FAIL wrap_wepulses got %0d want %0d", wes, WRAPN);
    end
    checks++;
    if (wwe !== 1'b0 || wgrant !== 2'b00) begin
      errors++;
      $display("FAIL wrap_quiet got we=%0h grant=%0h want 0 0",
               wwe, wgrant);
    end
  endtask

  initial begin
    wq.reqvalid = '0;
    wq.reqdata = '0;
    wfull = 1'b0;
    rq.reqvalid = '0;
    rq.reqdata = '0;
    full = 1'b0;
    m_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_full();
    test_drop();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifowrarb.md
# fifowrarb

Round-robin write-port arbiter sharing one asynchronous-FIFO write port between `nreq` requesters in the FIFO's write-clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst and drives registered `we`/`datain` into the FIFO. It honours the FIFO `full` flag and keeps a running count of committed writes.

## Interface
- `nreq`, 4: number of requesters, 2..8.
- `width`, 8: data width; equals the FIFO `width`.
- `maxburst`, 4: maximum beats per grant, ≥1.

- `clk`  in  1: clock; the FIFO write clock.
- `resetn`  in  1: asynchronous active-low reset. Asserts asynchronously, releases synchronously in the integration.
- `reqvalid`  in  nreq: per-requester data valid.
- `reqdata`  in  nreq*width: requester i data at bits [i*width +: width].
- `reqready`  out  nreq: per-requester accept, combinational.
- `full`  in  1: FIFO full flag, sampled as-is.
- `we`  out  1: FIFO write enable, registered.
- `datain`  out  width: FIFO write data, registered.
- `grant`  out  nreq: one-hot current owner, registered; 0 when idle.
- `busy`  out  1: high while in BURST.
- `wrcount`  out  16: number of committed writes, wraps modulo 2^16.

## Operation
- Two states, IDLE and BURST. Internal regs:
  - `rrptr`, $clog2(nreq) bits: highest-priority index.
  - `owner`: granted index.
  - `beats`, $clog2(maxburst+1) bits: beats in the current burst.
- IDLE:
  - `reqready` = 0, `grant` = 0.
  - If any `reqvalid` is set, pick the first set bit searching `rrptr`, `rrptr+1`, … modulo `nreq`.
  - On a pick: `owner` <= that index, `grant` <= its one-hot, `beats` <= 0, go to BURST.
  - With no valid, stay in IDLE; `rrptr` is unchanged.
- BURST:
  - `reqready[owner]` = `reqvalid[owner]` & !`full`; all other bits are 0.
  - Accept = `reqvalid[owner]` & `reqready[owner]`.
  - On accept: `we` <= 1, `datain` <= `reqdata[owner]`, `beats` <= `beats`+1, `wrcount` <= `wrcount`+1.
  - Otherwise `we` <= 0 and `datain` holds its value.
- Burst end, evaluated each BURST cycle:
  - Conditions: (accept & `beats`+1 == `maxburst`), or !`reqvalid[owner]`, or `full`.
  - Action: go to IDLE, `grant` <= 0, `rrptr` <= (`owner`+1) mod `nreq`.
  - The final accepted beat, if any, is still written.
- Fairness:
  - A requester that loses its turn cannot be regranted before every other valid requester has had one grant.
  - A lone requester is regranted after one IDLE cycle.
- `full` handling:
  - `full` is used combinationally in the cycle it is seen. The arbiter does not compensate for FIFO flag latency.
  - The integration drives `full` from a flag asserted at least 2 entries before true full, which covers the registered flag plus the registered `we`.
- Reset (`resetn`=0, any state, including mid-burst):
  - State IDLE, `rrptr`=0, `owner`=0, `beats`=0.
  - Outputs: `we`=0, `datain`=0, `grant`=0, `busy`=0, `wrcount`=0, `reqready`=0.
  - An in-flight beat is dropped, and no write is issued after reset release until a new grant.

## Timing
- Grant latency: a valid seen in IDLE at edge k gives `grant`/`busy` high after edge k and `reqready` possible in cycle k+1.
- Write latency: a beat accepted in cycle n gives `we`=1 and `datain` valid in cycle n+1, one cycle.
- Throughput: 1 beat/cycle within a burst. There is at least 1 non-accepting IDLE cycle between bursts, so sustained throughput is `maxburst`/(`maxburst`+1).
- `full` rising in cycle n: `reqready` is 0 in cycle n, no accept occurs in n, and BURST exits at the end of n.
- `reqvalid[owner]` and `full` falling together in the same cycle is a single burst end; `rrptr` advances once.
- `wrcount` increments in the same edge that registers `we`=1. It wraps 0xFFFF → 0x0000.

## Test plan
- Single requester 0 valid for 6 beats, data 0x10..0x15, `maxburst`=4 → `we` pulses carry 0x10..0x13, then 1 idle cycle, then 0x14, 0x15; `wrcount`=6.
- All 4 requesters continuously valid → grant order 0,1,2,3,0, each holding exactly 4 `we` beats with 1 IDLE cycle between grants; `rrptr` cycles 1,2,3,0.
- `full` raised on the 3rd beat of requester 1's burst → `reqready[1]`=0 that cycle, only 2 writes; the next grant goes to requester 2 even though 1 is still valid.
- Requester 2 drops valid after 1 beat while requester 0 is valid → burst ends after 1 write; the next grant goes to requester 3 if valid, else 0.
- `resetn` pulled low mid-burst between edges → `we`, `grant`, `reqready`, `wrcount` go 0 immediately; after release, the first grant goes to requester 0.
- `wrcount` preloaded near wrap by running 65 540 single-requester beats → `wrcount`=4 and no spurious `we`.
